burst_rr_arbiter: RTL and testbench

//  Round-robin arbiter with burst lock. Shares one downstream resource (single valid/ready sink) among N requesters.
//  A requester that wins keeps the grant until its beat flagged last is accepted.

---
 rtl/arb_pkg.sv | 8 +
 rtl/rr_pick.sv | 36 +++
 rtl/burst_rr_arbiter.sv | 137 +++++++++++++
 tb/tb_burst_rr_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the burst round-robin arbiter.
package arb_pkg;

  typedef enum logic {ST_IDLE = 1'b0, ST_LOCK = 1'b1} arb_state_t;

  localparam int BEAT_CNT_W = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: rotate req so ptr lands on bit 0,
// take the lowest set bit, rotate the one-hot back into place.
module rr_pick #(
  parameter  int N   = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] idx,
  output logic           any
);

  logic [N-1:0] rot;
  logic [N-1:0] rot_gnt;
  int           pos;

  function automatic int wrap(input int v);
    return (v >= N) ? v - N : v;
  endfunction

  // Rotate, fixed-priority pick from bit 0 upward, rotate back.
  always_comb begin
    rot     = '0;
    rot_gnt = '0;
    gnt     = '0;
    pos     = 0;
    for (int i = 0; i < N; i++) rot[i] = req[IDW'(wrap(i + int'(ptr)))];
    for (int i = N - 1; i >= 0; i--) if (rot[i]) pos = i;
    any = |rot;
    if (any) rot_gnt[IDW'(pos)] = 1'b1;
    for (int i = 0; i < N; i++) gnt[IDW'(wrap(i + int'(ptr)))] = rot_gnt[i];
    idx = any ? IDW'(wrap(pos + int'(ptr))) : '0;
  end

endmodule

// File: rtl/burst_rr_arbiter.sv
// Round-robin arbiter with burst lock: a winner keeps the grant until its
// last beat is accepted, then one idle cycle before the next pick.
// Optional burst watchdog enabled by defining BURST_WDOG_EN.
module burst_rr_arbiter #(
  parameter  int N        = 4,
  parameter  int MAX_HOLD = 64,
  localparam int IDW      = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   req_last,
  input  logic           res_ready,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id,
  output logic           busy,
  output logic           res_valid,
  output logic           res_last,
  output logic [7:0]     beat_cnt,
  output logic           wdog_err
);
  import arb_pkg::*;

  arb_state_t            state_q, state_d;
  logic [N-1:0]          grant_q, grant_d;
  logic [IDW-1:0]        gid_q, gid_d;
  logic [IDW-1:0]        ptr_q, ptr_d;
  logic [BEAT_CNT_W-1:0] beat_q, beat_d;

  logic [N-1:0]   pick_gnt;
  logic [IDW-1:0] pick_idx;
  logic           pick_any;
  logic           xfer, last_xfer, rel_wdog;

  rr_pick #(.N(N)) u_pick (
    .req (req),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign busy      = |grant_q;
  assign grant     = grant_q;
  assign grant_id  = gid_q;
  assign beat_cnt  = beat_q;
  assign res_valid = busy & req[gid_q];
  assign res_last  = busy & req_last[gid_q];
  assign xfer      = res_valid & res_ready;
  assign last_xfer = xfer & res_last;

`ifdef BURST_WDOG_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              wdog_q, wdog_d;

  // Forced release fires on the last allowed LOCK cycle unless the burst ends anyway.
  assign rel_wdog = (state_q == ST_LOCK) & ~last_xfer & (hold_q == HOLD_W'(MAX_HOLD - 1));
  assign wdog_err = wdog_q;

  // Hold counter: zero while idle so it starts fresh on entering LOCK.
  always_comb begin
    hold_d = hold_q;
    wdog_d = 1'b0;
    if (state_q == ST_IDLE) begin
      hold_d = '0;
    end else begin
      hold_d = hold_q + HOLD_W'(1);
      wdog_d = rel_wdog;
    end
  end

  // Watchdog registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
      wdog_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      wdog_q <= wdog_d;
    end
  end
`else
  logic unused_max_hold;
  assign unused_max_hold = (MAX_HOLD > 0);
  assign rel_wdog        = 1'b0;
  assign wdog_err        = 1'b0;
`endif

  // FSM: pick in IDLE, hold ownership in LOCK until last beat (or watchdog).
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gid_d   = gid_q;
    ptr_d   = ptr_q;
    beat_d  = beat_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_LOCK;
          grant_d = pick_gnt;
          gid_d   = pick_idx;
          beat_d  = '0;
        end
      end
      default: begin
        if (xfer && beat_q != {BEAT_CNT_W{1'b1}}) beat_d = beat_q + BEAT_CNT_W'(1);
        if (last_xfer || rel_wdog) begin
          state_d = ST_IDLE;
          grant_d = '0;
          gid_d   = '0;
          beat_d  = '0;
          ptr_d   = (gid_q == IDW'(N - 1)) ? '0 : gid_q + IDW'(1);
        end
      end
    endcase
  end

  // State, ownership, pointer and beat counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      gid_q   <= '0;
      ptr_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
      beat_q  <= beat_d;
    end
  end

endmodule

// File: tb/tb_burst_rr_arbiter.sv
// Directed bench for burst_rr_arbiter; a scoreboard queue holds the expected
// owner of each upcoming burst and is checked whenever busy rises.
module tb_burst_rr_arbiter;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req, req_last;
  logic       res_ready;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       busy, res_valid, res_last, wdog_err;
  logic [7:0] beat_cnt;

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  logic prev_busy = 1'b0;

  burst_rr_arbiter #(.N(N), .MAX_HOLD(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_last  (req_last),
    .res_ready (res_ready),
    .grant     (grant),
    .grant_id  (grant_id),
    .busy      (busy),
    .res_valid (res_valid),
    .res_last  (res_last),
    .beat_cnt  (beat_cnt),
    .wdog_err  (wdog_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; on each new grant pop and compare the expected owner.
  task automatic tick();
    int e;
    @(negedge clk);
    if (busy === 1'b1 && prev_busy !== 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_unexpected_grant: got grant_id %0d expected no grant", grant_id);
      end else begin
        e = exp_q.pop_front();
        chk("sb_grant_id", 32'(grant_id), 32'(e));
        chk("sb_grant_onehot", 32'(grant), 32'(1) << e);
      end
    end
    prev_busy = busy;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int beats;
    rst = 1'b1; req = '0; req_last = '0; res_ready = 1'b0;
    tick(); tick();
    // reset state
    chk("rst_grant", 32'(grant), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_beat", 32'(beat_cnt), 0);
    chk("rst_wdog", 32'(wdog_err), 0);
    chk("rst_res_valid", 32'(res_valid), 0);

    // T1: all request, single-beat bursts -> 0,1,2,3,0 with idle gaps
    rst = 1'b0; req = 4'b1111; req_last = 4'b1111; res_ready = 1'b1;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    exp_q.push_back(3); exp_q.push_back(0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("t1_busy_pattern", 32'(busy), 32'(k % 2));
    end
    req = '0; req_last = '0;

    // T2: requester 2, 5-beat burst, ready toggling
    res_ready = 1'b0;
    req = 4'b0100;
    exp_q.push_back(2);
    tick();
    chk("t2_beat0", 32'(beat_cnt), 0);
    beats = 0;
    for (int c = 0; c < 9; c++) begin
      res_ready = (c % 2 == 0);
      req_last = (beats == 4) ? 4'b0100 : 4'b0000;
      chk("t2_res_valid", 32'(res_valid), 1);
      tick();
      if (res_ready) beats++;
      if (beats < 5) begin
        chk("t2_busy", 32'(busy), 1);
        chk("t2_grant_id", 32'(grant_id), 2);
        chk("t2_beat_cnt", 32'(beat_cnt), 32'(beats));
      end else begin
        chk("t2_released", 32'(busy), 0);
        chk("t2_beat_clr", 32'(beat_cnt), 0);
      end
    end
    req = '0; req_last = '0; res_ready = 1'b0;
    tick();
    chk("t2_idle", 32'(busy), 0);

    // T3: owner drops req mid-burst while requester 0 waits
    req = 4'b0010;
    exp_q.push_back(1);
    tick();
    res_ready = 1'b1;
    tick();
    chk("t3_beat1", 32'(beat_cnt), 1);
    req = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t3_grant_held", 32'(grant), 32'h2);
      chk("t3_res_valid", 32'(res_valid), 0);
      chk("t3_beat_frozen", 32'(beat_cnt), 1);
    end
    req = 4'b0011; req_last = 4'b0010;
    tick();
    chk("t3_release", 32'(busy), 0);
    exp_q.push_back(0);   // pointer now 2, only 0 and 1 request -> wrap to 0
    tick();
    req = 4'b0001; req_last = 4'b0001;
    tick();
    chk("t3_release0", 32'(busy), 0);
    req = '0; req_last = '0;
    tick();

    // T4: bring pointer to 3, then req=1001 -> 3 then 0
    req = 4'b0100; req_last = 4'b0100;
    exp_q.push_back(2);
    tick(); tick();
    req = 4'b1001; req_last = 4'b1001;
    exp_q.push_back(3); exp_q.push_back(0);
    tick(); tick(); tick(); tick();
    req = '0; req_last = '0;
    tick();

    // T5: reset mid-burst at beat 2
    req = 4'b0010; req_last = '0; res_ready = 1'b1;
    exp_q.push_back(1);
    tick(); tick(); tick();
    chk("t5_beat2", 32'(beat_cnt), 2);
    rst = 1'b1;
    tick();
    chk("t5_rst_grant", 32'(grant), 0);
    chk("t5_rst_beat", 32'(beat_cnt), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    rst = 1'b0; req = 4'b0110; res_ready = 1'b0;
    exp_q.push_back(1);   // pointer back at 0
    tick();
    req_last = 4'b0110; res_ready = 1'b1;
    tick();
    req = '0; req_last = '0;
    tick();

    // T6: owner never sends last (pointer is 2, req=0011 -> owner 0)
    req = 4'b0011; req_last = '0; res_ready = 1'b1;
    exp_q.push_back(0);
    tick();
`ifdef BURST_WDOG_EN
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk("t6_hold_busy", 32'(busy), 1);
      chk("t6_no_wdog", 32'(wdog_err), 0);
      chk("t6_beat", 32'(beat_cnt), 32'(k));
    end
    exp_q.push_back(1);
    tick();
    chk("t6_forced_release", 32'(busy), 0);
    chk("t6_wdog_pulse", 32'(wdog_err), 1);
    tick();
    chk("t6_wdog_clear", 32'(wdog_err), 0);
    chk("t6_next_owner", 32'(grant_id), 1);
`else
    for (int m = 1; m <= 300; m++) begin
      tick();
      chk("t6_hold_busy", 32'(busy), 1);
      chk("t6_hold_owner", 32'(grant_id), 0);
      chk("t6_no_wdog", 32'(wdog_err), 0);
      if (m == 100) chk("t6_beat100", 32'(beat_cnt), 100);
    end
    chk("t6_beat_sat", 32'(beat_cnt), 255);
`endif
    rst = 1'b1; req = '0;
    tick();
    chk("end_rst_busy", 32'(busy), 0);
    rst = 1'b0;
    tick();

    chk("sb_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
